ni_packetizer: RTL and testbench

NI_PACKETIZER -- requirements
Module: ni_packetizer

---
 rtl/noc_pkg.sv | 44 ++++
 rtl/credit_counter.sv | 29 ++
 rtl/ni_packetizer.sv | 122 ++++++++++++
 tb/tb_ni_packetizer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC flit types, head-flit field layout and coordinate/length widths
package noc_pkg;

  localparam int COORD_W = 3;
  localparam int LEN_W   = 4;
  localparam int HEAD_W  = 16;

  localparam int HEAD_DST_X_LSB = 0;
  localparam int HEAD_DST_Y_LSB = 3;
  localparam int HEAD_SRC_X_LSB = 6;
  localparam int HEAD_SRC_Y_LSB = 9;
  localparam int HEAD_LEN_LSB   = 12;

  typedef enum logic [1:0] {
    FT_HEAD     = 2'b00,
    FT_BODY     = 2'b01,
    FT_TAIL     = 2'b10,
    FT_HEADTAIL = 2'b11
  } flit_type_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAD = 2'b01,
    ST_BODY = 2'b10
  } ni_state_t;

  function automatic logic [HEAD_W-1:0] make_head(
    input logic [COORD_W-1:0] dst_x,
    input logic [COORD_W-1:0] dst_y,
    input logic [COORD_W-1:0] src_x,
    input logic [COORD_W-1:0] src_y,
    input logic [LEN_W-1:0]   len
  );
    logic [HEAD_W-1:0] h;
    h = '0;
    h[HEAD_DST_X_LSB +: COORD_W] = dst_x;
    h[HEAD_DST_Y_LSB +: COORD_W] = dst_y;
    h[HEAD_SRC_X_LSB +: COORD_W] = src_x;
    h[HEAD_SRC_Y_LSB +: COORD_W] = src_y;
    h[HEAD_LEN_LSB   +: LEN_W]   = len;
    return h;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// rtl/credit_counter.sv - downstream credit counter, saturating at DEPTH with overflow flag
module credit_counter #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // A returned credit with no simultaneous send while already full is dropped.
  assign overflow = inc && !dec && (count == FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= FULL;
    end else if (inc && !dec) begin
      if (count != FULL) count <= count + 1'b1;
    end else if (dec && !inc) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ni_packetizer.sv
// rtl/ni_packetizer.sv - network-interface packetizer: request + body words to credit-gated head/body/tail flits
module ni_packetizer
  import noc_pkg::*;
#(
  parameter int x_size    = 4,
  parameter int y_size    = 4,
  parameter int FLIT_W    = 32,
  parameter int MAX_LEN   = 8,
  parameter int BUF_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [$clog2(x_size)-1:0] id_x,
  input  logic [$clog2(y_size)-1:0] id_y,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [2:0]                req_dst_x,
  input  logic [2:0]                req_dst_y,
  input  logic [3:0]                req_len,
  input  logic                      data_valid,
  output logic                      data_ready,
  input  logic [FLIT_W-1:0]         data,
  output logic                      flit_valid,
  output logic [1:0]                flit_type,
  output logic [FLIT_W-1:0]         flit_data,
  input  logic                      credit_in,
  output logic                      err
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  ni_state_t            state;
  logic [COORD_W-1:0]   dst_x_q;
  logic [COORD_W-1:0]   dst_y_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     remaining;
  logic [CW-1:0]        credits;
  logic                 overflow;
  logic                 has_credit;
  logic                 send;
  logic                 len_too_big;

  assign has_credit  = (credits != '0);
  assign req_ready   = rst_n && (state == ST_IDLE);
  assign data_ready  = rst_n && (state == ST_BODY) && has_credit;
  assign len_too_big = (req_len > MAX_LEN_L);

  // One credit is spent on every flit registered this edge.
  assign send = rst_n && has_credit &&
                ((state == ST_HEAD) || ((state == ST_BODY) && data_valid));

  credit_counter #(
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_credit (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (credit_in),
    .dec      (send),
    .count    (credits),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      flit_valid <= 1'b0;
      flit_type  <= 2'b00;
      flit_data  <= '0;
      err        <= 1'b0;
      remaining  <= '0;
      len_q      <= '0;
      dst_x_q    <= '0;
      dst_y_q    <= '0;
    end else begin
      flit_valid <= 1'b0;
      if (overflow) err <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            dst_x_q <= req_dst_x;
            dst_y_q <= req_dst_y;
            if (len_too_big) begin
              len_q     <= MAX_LEN_L;
              remaining <= MAX_LEN_L;
              err       <= 1'b1;
            end else begin
              len_q     <= req_len;
              remaining <= req_len;
            end
            state <= ST_HEAD;
          end
        end

        ST_HEAD: begin
          if (has_credit) begin
            flit_valid <= 1'b1;
            flit_type  <= (len_q == '0) ? FT_HEADTAIL : FT_HEAD;
            flit_data  <= FLIT_W'(make_head(dst_x_q, dst_y_q, COORD_W'(id_x),
                                            COORD_W'(id_y), len_q));
            state      <= (len_q == '0) ? ST_IDLE : ST_BODY;
          end
        end

        ST_BODY: begin
          if (data_valid && has_credit) begin
            flit_valid <= 1'b1;
            flit_data  <= data;
            flit_type  <= (remaining == LEN_W'(1)) ? FT_TAIL : FT_BODY;
            remaining  <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ni_packetizer.sv
// tb/tb_ni_packetizer.sv - randomized self-checking bench for ni_packetizer against a packet-level reference model
module tb_ni_packetizer;

  localparam int BUF  = 4;
  localparam int MAXL = 8;
  localparam logic [1:0] T_HEAD = 2'b00, T_BODY = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  id_x, id_y;
  logic        req_valid, req_ready;
  logic [2:0]  req_dst_x, req_dst_y;
  logic [3:0]  req_len;
  logic        data_valid, data_ready;
  logic [31:0] data;
  logic        flit_valid;
  logic [1:0]  flit_type;
  logic [31:0] flit_data;
  logic        credit_in;
  logic        err;

  always #5 clk = ~clk;

  ni_packetizer #(
    .x_size(4), .y_size(4), .FLIT_W(32), .MAX_LEN(MAXL), .BUF_DEPTH(BUF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_x(id_x), .id_y(id_y),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst_x(req_dst_x), .req_dst_y(req_dst_y), .req_len(req_len),
    .data_valid(data_valid), .data_ready(data_ready), .data(data),
    .flit_valid(flit_valid), .flit_type(flit_type), .flit_data(flit_data),
    .credit_in(credit_in), .err(err)
  );

  typedef struct packed {
    logic [1:0]  t;
    logic [31:0] d;
  } flit_t;

  flit_t       expq[$];
  flit_t       mon_f;
  int          fcyc[$];
  int          n_cmp = 0, n_mis = 0;
  int          model_cred = BUF;
  logic        model_err = 1'b0;
  int          nflits = 0, cyc = 0;
  logic [31:0] last_head = '0;
  logic        pre_rst = 1'b0, pre_ci = 1'b0, pre_acc = 1'b0;
  logic [3:0]  pre_len = '0;
  logic        auto_credit = 1'b0, manual_credit = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] head_word(input int dx, input int dy, input int sx,
                                            input int sy, input int len);
    return 32'(dx + dy * 8 + sx * 64 + sy * 512 + len * 4096);
  endfunction

  always @(negedge clk) begin
    pre_rst = rst_n;
    pre_ci  = credit_in;
    pre_acc = rst_n && req_valid && req_ready;
    pre_len = req_len;
  end

  // Packet-level scoreboard: flits in order, credit balance and sticky error.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!pre_rst) begin
      model_cred = BUF;
      model_err  = 1'b0;
      expq.delete();
      check("rst_flit_valid", flit_valid, 0);
      check("rst_flit_type", flit_type, 0);
      check("rst_flit_data", flit_data, 0);
      check("rst_err", err, 0);
      check("rst_credits", dut.u_credit.count, BUF);
    end else begin
      if (flit_valid) begin
        check("flit_expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          mon_f = expq.pop_front();
          check("flit_type", flit_type, mon_f.t);
          check("flit_data", flit_data, mon_f.d);
        end
        nflits++;
        fcyc.push_back(cyc);
        if (flit_type == T_HEAD || flit_type == T_HT) last_head = flit_data;
      end
      if (pre_acc) begin
        check("accept_flit_gap", flit_valid, 0);
        if (pre_len > MAXL) model_err = 1'b1;
      end
      if (pre_ci && !flit_valid && model_cred == BUF) model_err = 1'b1;
      else model_cred = model_cred + int'(pre_ci) - int'(flit_valid);
      check("credits", dut.u_credit.count, model_cred);
      check("err", err, model_err);
    end
  end

  initial begin
    credit_in = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      credit_in = auto_credit ? (model_cred < BUF && ($urandom % 2 == 1)) : manual_credit;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    data_valid = 1'b0;
    step();
    check("rst_req_ready", req_ready, 0);
    check("rst_data_ready", data_ready, 0);
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic send_pkt(input int dx, input int dy, input int len, input bit bubbles,
                          input int stop_words);
    int cl, limit, i, guard;
    logic [31:0] w[$];
    flit_t f;
    bit hs, got;
    cl  = (len > MAXL) ? MAXL : len;
    f.t = (cl == 0) ? T_HT : T_HEAD;
    f.d = head_word(dx, dy, id_x, id_y, cl);
    expq.push_back(f);
    for (int k = 0; k < cl; k++) begin
      w.push_back($urandom);
      f.t = (k == cl - 1) ? T_TAIL : T_BODY;
      f.d = w[k];
      expq.push_back(f);
    end
    req_dst_x = 3'(dx);
    req_dst_y = 3'(dy);
    req_len   = 4'(len);
    req_valid = 1'b1;
    got = 1'b0;
    for (guard = 0; guard < 50 && !got; guard++) begin
      @(negedge clk);
      got = req_ready;
      step();
    end
    req_valid = 1'b0;
    req_len   = 4'($urandom);
    check("req_accepted", got, 1);
    if (!got) return;
    limit = (stop_words > 0) ? stop_words : cl;
    i = 0;
    guard = 0;
    while (i < limit && guard < 400) begin
      data       = w[i];
      data_valid = bubbles ? 1'($urandom % 2) : 1'b1;
      @(negedge clk);
      hs = data_valid && data_ready;
      step();
      if (hs) i++;
      guard++;
    end
    data_valid = 1'b0;
    data       = $urandom;
    check("data_words_taken", i, limit);
    if (stop_words == 0) begin
      guard = 0;
      while (expq.size() != 0 && guard < 400) begin
        step();
        guard++;
      end
      check("drained", expq.size(), 0);
    end
  endtask

  initial begin
    int base, guard, len;
    rst_n = 1'b0; id_x = 2'd1; id_y = 2'd0;
    req_valid = 1'b0; req_dst_x = '0; req_dst_y = '0; req_len = '0;
    data_valid = 1'b0; data = '0;
    do_reset();

    // single HEADTAIL packet
    auto_credit = 1'b0;
    check("t029_cred_init", dut.u_credit.count, BUF);
    send_pkt(2, 3, 0, 1'b0, 0);
    check("t029_head", last_head, head_word(2, 3, 1, 0, 0));
    check("t029_cred", dut.u_credit.count, BUF - 1);

    // back-to-back body words
    do_reset();
    base = nflits;
    fcyc.delete();
    send_pkt(5, 6, 3, 1'b0, 0);
    check("t030_nflits", nflits - base, 4);
    check("t030_consecutive", (fcyc.size() >= 4) ? fcyc[3] - fcyc[0] : -1, 3);
    check("t030_cred", dut.u_credit.count, BUF - 4);

    // credit exhaustion stalls after BUF flits
    do_reset();
    base = nflits;
    fork
      send_pkt(1, 1, 6, 1'b0, 0);
      begin
        repeat (20) step();
        check("t031_stall_flits", nflits - base, BUF);
        check("t031_data_ready", data_ready, 0);
        manual_credit = 1'b1;
        step();
        manual_credit = 1'b0;
        repeat (5) step();
        check("t031_one_more", nflits - base, BUF + 1);
        auto_credit = 1'b1;
      end
    join
    auto_credit = 1'b0;

    // simultaneous credit and send, then overflow
    do_reset();
    base = nflits;
    fork
      send_pkt(3, 4, 5, 1'b0, 0);
      begin
        guard = 0;
        while (nflits - base < 2 && guard < 50) begin step(); guard++; end
        check("t032_cred_before", dut.u_credit.count, 2);
        manual_credit = 1'b1;
        step();
        manual_credit = 1'b0;
        check("t032_flit_sent", nflits - base, 3);
        check("t032_cred_same", dut.u_credit.count, 2);
        auto_credit = 1'b1;
      end
    join
    guard = 0;
    while (model_cred != BUF && guard < 100) begin step(); guard++; end
    auto_credit = 1'b0;
    step();
    manual_credit = 1'b1;
    step();
    manual_credit = 1'b0;
    check("t032_sat_cred", dut.u_credit.count, BUF);
    check("t032_err", err, 1);

    // reset mid-packet abandons it
    do_reset();
    base = nflits;
    send_pkt(6, 7, 5, 1'b0, 2);
    check("t033_partial", nflits - base, 3);
    rst_n = 1'b0;
    step();
    check("t033_flit_valid", flit_valid, 0);
    check("t033_cred", dut.u_credit.count, BUF);
    check("t033_req_ready", req_ready, 0);
    rst_n = 1'b1;
    step();
    send_pkt(1, 2, 1, 1'b0, 0);

    // oversize request clamped
    do_reset();
    auto_credit = 1'b1;
    base = nflits;
    send_pkt(0, 7, 12, 1'b1, 0);
    check("t034_nflits", nflits - base, MAXL + 1);
    check("t034_len_field", last_head[15:12], MAXL);
    check("t034_err", err, 1);

    // random traffic
    do_reset();
    auto_credit = 1'b1;
    repeat (40) begin
      id_x = 2'($urandom);
      id_y = 2'($urandom);
      len  = ($urandom % 5 == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      send_pkt(int'($urandom % 8), int'($urandom % 8), len, 1'($urandom % 2), 0);
      repeat ($urandom % 3) step();
    end
    auto_credit = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
